tx_frame_arbiter: RTL

Round-robin scheduler that shares the single serial byte transmitter (load/send/tx_end interface) among NREQ requesters, such as per-channel converter front ends.
- Captures one requester's byte and sequences the transmitter's load and send strobes.
- Gates the send strobe on `dsr`.
- Waits for end-of-frame, then returns a one-cycle completion pulse to the owning requester.
- Sits between the channel sequencers and the serial transmitter/interface controller.

---
 rtl/tx_frame_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/tx_frame_arbiter.sv
// Round-robin owner of the shared serial byte transmitter (load/send/tx_end).
// Optional WAIT_END abort counter: define TX_FRAME_ARBITER_TIMEOUT_EN.
module tx_frame_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 2047
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic              dsr,
  input  logic              tx_end,
  output logic              tx_load,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  output logic              busy,
  output logic [2:0]        cur_id,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_DSR, SEND, WAIT_END, DONE
  } state_t;

  state_t          state, state_n;
  logic [2:0]      ptr, ptr_n;
  logic [2:0]      cur_n, pick;
  logic [3:0]      idx;
  logic            found;
  logic [7:0]      data_n;
  logic            load_n, send_n;
  logic [NREQ-1:0] done_n, err_n;
  logic [7:0]      req_pad;
  logic [63:0]     data_pad;
  logic [7:0]      id_hot;

  assign req_pad  = 8'(req);
  assign data_pad = 64'(req_data);
  assign id_hot   = 8'b1 << cur_id;

`ifdef TX_FRAME_ARBITER_TIMEOUT_EN
  localparam logic [10:0] TMO_LAST = 11'(TIMEOUT - 1);
  logic [10:0] cnt, cnt_n;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // first requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= 4'(NREQ))
        idx = idx - 4'(NREQ);
      if (!found && req_pad[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cur_n   = cur_id;
    data_n  = tx_data;
    load_n  = 1'b0;
    send_n  = 1'b0;
    done_n  = '0;
    err_n   = '0;
`ifdef TX_FRAME_ARBITER_TIMEOUT_EN
    cnt_n   = cnt;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          cur_n   = pick;
          data_n  = data_pad[{pick, 3'b000} +: 8];
          load_n  = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD, WAIT_DSR: begin
        if (dsr) begin
          send_n  = 1'b1;
          state_n = SEND;
        end else begin
          state_n = WAIT_DSR;
        end
      end
      SEND: begin
        state_n = WAIT_END;
`ifdef TX_FRAME_ARBITER_TIMEOUT_EN
        cnt_n   = '0;
`endif
      end
      WAIT_END: begin
        // tx_end on the expiry cycle still counts as a clean finish
        if (tx_end) begin
          done_n  = id_hot[NREQ-1:0];
          state_n = DONE;
        end
`ifdef TX_FRAME_ARBITER_TIMEOUT_EN
        else if (cnt == TMO_LAST) begin
          err_n   = id_hot[NREQ-1:0];
          state_n = DONE;
        end else begin
          cnt_n = cnt + 11'd1;
        end
`endif
      end
      DONE: begin
        ptr_n   = (cur_id == 3'(NREQ - 1)) ? 3'd0 : cur_id + 3'd1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cur_id  <= '0;
      tx_data <= '0;
      tx_load <= 1'b0;
      tx_send <= 1'b0;
      busy    <= 1'b0;
      done    <= '0;
      err     <= '0;
`ifdef TX_FRAME_ARBITER_TIMEOUT_EN
      cnt     <= '0;
`endif
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cur_id  <= cur_n;
      tx_data <= data_n;
      tx_load <= load_n;
      tx_send <= send_n;
      busy    <= (state_n != IDLE);
      done    <= done_n;
      err     <= err_n;
`ifdef TX_FRAME_ARBITER_TIMEOUT_EN
      cnt     <= cnt_n;
`endif
    end
  end

endmodule
